// File: rtl/model_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : model_pkg
//  Description : Shared constants for the row scheduler: frame geometry
//                defaults, class/index widths and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package model_pkg;

    localparam int c_rows_def = 28;
    localparam int c_cols_def = 28;
    localparam int c_class_w  = 4;
    localparam int c_idx_w    = 5;
    localparam int c_state_w  = 2;

    localparam logic [c_state_w-1:0] c_st_idle     = 2'd0;
    localparam logic [c_state_w-1:0] c_st_issue    = 2'd1;
    localparam logic [c_state_w-1:0] c_st_wait_res = 2'd2;
    localparam logic [c_state_w-1:0] c_st_out      = 2'd3;

endpackage
`default_nettype wire

// File: rtl/model_row_mux.sv
`default_nettype none
// ============================================================================
//  Module      : model_row_mux
//  Description : Combinational selection of one row from the frame register.
//  Revision    : 1.0 - initial release
// ============================================================================
module model_row_mux
    import model_pkg::*;
#(
    parameter int ROWS = c_rows_def,
    parameter int COLS = c_cols_def
) (
    input  logic [ROWS*COLS-1:0] i_frame,
    input  logic [c_idx_w-1:0]   i_sel,
    output logic [COLS-1:0]      o_row
);

    always_comb begin
        o_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(i_sel) == r) o_row = i_frame[r*COLS +: COLS];
        end
    end

endmodule
`default_nettype wire

// File: rtl/model_row_sched.sv
`default_nettype none
// ============================================================================
//  Module      : model_row_sched
//  Description : Accepts a binary image, issues it row by row to a compute
//                engine, waits for the class result and presents it.
//                MODEL_SCHED_SKIP_ZERO_EN: skip all-zero rows during issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module model_row_sched
    import model_pkg::*;
#(
    parameter int ROWS = c_rows_def,
    parameter int COLS = c_cols_def
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 valid_i,
    input  logic [ROWS*COLS-1:0] data_i,
    output logic                 ready_o,
    output logic                 row_valid_o,
    output logic [COLS-1:0]      row_data_o,
    output logic [c_idx_w-1:0]   row_idx_o,
    output logic                 row_last_o,
    input  logic                 row_ready_i,
    input  logic                 res_valid_i,
    input  logic [c_class_w-1:0] res_i,
    output logic                 valid_o,
    output logic [c_class_w-1:0] data_o,
    input  logic                 ready_i
);

    localparam logic [c_idx_w-1:0] c_last_row = c_idx_w'(ROWS - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_idx_w-1:0]   r_row_cnt;
    logic [ROWS*COLS-1:0] r_frame;
    logic [c_class_w-1:0] r_data;

    logic                 w_accept;
    logic                 w_issue;
    logic                 w_at_last;
    logic                 w_row_valid;
    logic                 w_row_last;
    logic [COLS-1:0]      w_row;

    model_row_mux #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_row_mux (
        .i_frame (r_frame),
        .i_sel   (r_row_cnt),
        .o_row   (w_row)
    );

    assign w_accept  = (r_state == c_st_idle) && valid_i;
    assign w_issue   = (r_state == c_st_issue);
    assign w_at_last = (r_row_cnt == c_last_row);

`ifdef MODEL_SCHED_SKIP_ZERO_EN
    logic [ROWS-1:0] w_row_nz;
    logic            w_nz_after;

    for (genvar r = 0; r < ROWS; r++) begin : g_row_nz
        assign w_row_nz[r] = |r_frame[r*COLS +: COLS];
    end

    // A row is last when no later row carries any set pixel.
    always_comb begin
        w_nz_after = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (r > int'(r_row_cnt) && w_row_nz[r]) w_nz_after = 1'b1;
        end
    end

    // Final row is always issued so an empty image still produces a frame.
    assign w_row_valid = w_issue && ((|w_row) || w_at_last);
    assign w_row_last  = w_row_valid && (w_at_last || !w_nz_after);
`else
    assign w_row_valid = w_issue;
    assign w_row_last  = w_issue && w_at_last;
`endif

    always_ff @(posedge clk_i) begin
        if (w_accept) r_frame <= data_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= c_st_idle;
            r_row_cnt <= '0;
            r_data    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (valid_i) begin
                        r_row_cnt <= '0;
                        r_state   <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    if (w_row_valid && row_ready_i) begin
                        // Counter holds on the final row so it never passes ROWS-1.
                        if (w_row_last) r_state   <= c_st_wait_res;
                        else            r_row_cnt <= r_row_cnt + 1'b1;
                    end else if (!w_row_valid) begin
                        r_row_cnt <= r_row_cnt + 1'b1;
                    end
                end
                c_st_wait_res: begin
                    if (res_valid_i) begin
                        r_data  <= res_i;
                        r_state <= c_st_out;
                    end
                end
                c_st_out: begin
                    if (ready_i) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign ready_o     = (r_state == c_st_idle);
    assign row_valid_o = w_row_valid;
    assign row_data_o  = w_row;
    assign row_idx_o   = r_row_cnt;
    assign row_last_o  = w_row_last;
    assign valid_o     = (r_state == c_st_out);
    assign data_o      = r_data;

endmodule
`default_nettype wire

// File: tb/tb_model_row_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_model_row_sched
//  Description : Self-checking bench for model_row_sched against a frame-level
//                reference model (list of rows expected to be issued).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_model_row_sched;

    localparam int ROWS = 28;
    localparam int COLS = 28;
    localparam int N    = ROWS * COLS;

    typedef logic [N-1:0] frame_t;

    logic            clk_i = 1'b0;
    logic            reset_ni;
    logic            valid_i;
    logic [N-1:0]    data_i;
    logic            ready_o;
    logic            row_valid_o;
    logic [COLS-1:0] row_data_o;
    logic [4:0]      row_idx_o;
    logic            row_last_o;
    logic            row_ready_i;
    logic            res_valid_i;
    logic [3:0]      res_i;
    logic            valid_o;
    logic [3:0]      data_o;
    logic            ready_i;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    model_row_sched #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .row_valid_o (row_valid_o),
        .row_data_o  (row_data_o),
        .row_idx_o   (row_idx_o),
        .row_last_o  (row_last_o),
        .row_ready_i (row_ready_i),
        .res_valid_i (res_valid_i),
        .res_i       (res_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .ready_i     (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: rows a frame must issue, in order.
    task automatic build_issue(input frame_t f);
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
`ifdef MODEL_SCHED_SKIP_ZERO_EN
            if (f[r*COLS +: COLS] != '0) exp_q.push_back(r);
`else
            exp_q.push_back(r);
`endif
        end
        if (exp_q.size() == 0) exp_q.push_back(ROWS - 1);
    endtask

    function automatic frame_t rand_frame(input int zero_pct);
        frame_t          f;
        logic [COLS-1:0] row;
        f = '0;
        for (int r = 0; r < ROWS; r++) begin
            row = COLS'($urandom);
            if (row == '0) row[0] = 1'b1;
            if (int'($urandom_range(99)) < zero_pct) row = '0;
            f[r*COLS +: COLS] = row;
        end
        return f;
    endfunction

    task automatic scramble_data();
        for (int i = 0; i < N; i++) data_i[i] = 1'($urandom);
    endtask

    task automatic run_frame(input frame_t f, input int stall_row, input int stall_len,
                             input int out_stall, input bit rand_bp, input logic [3:0] res,
                             output int lat, output int nissued);
        int stalled;
        int cyc;
        bit rdy;
        bit rv;
        lat = -1;
        nissued = 0;
        stalled = 0;
        build_issue(f);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: ready_o=%b expected 1", ready_o);
        end
        valid_i = 1'b1;
        data_i  = f;
        step();
        valid_i = 1'b0;
        scramble_data();
        cyc = 1;
        while (exp_q.size() > 0 && cyc < 400) begin
            checks++;
            if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL issue_hs: ready_o=%b valid_o=%b expected 0/0", ready_o, valid_o);
            end
            res_valid_i = 1'($urandom);
            res_i       = ~res;
            if (row_valid_o === 1'b1) begin
                checks++;
                if (row_idx_o !== 5'(exp_q[0]) || row_data_o !== f[exp_q[0]*COLS +: COLS] ||
                    row_last_o !== (exp_q.size() == 1)) begin
                    errors++;
                    $display("FAIL row: idx=%0d data=%h last=%b expected idx=%0d data=%h last=%b",
                             row_idx_o, row_data_o, row_last_o, exp_q[0],
                             f[exp_q[0]*COLS +: COLS], exp_q.size() == 1);
                end
                if (exp_q[0] == stall_row && stalled < stall_len) begin
                    rdy = 1'b0;
                    stalled++;
                end else begin
                    rdy = rand_bp ? 1'($urandom) : 1'b1;
                end
                row_ready_i = rdy;
                step();
                if (rdy) begin
                    void'(exp_q.pop_front());
                    nissued++;
                end
            end else begin
`ifndef MODEL_SCHED_SKIP_ZERO_EN
                checks++;
                errors++;
                $display("FAIL row_valid: row_valid_o=%b expected 1", row_valid_o);
`endif
                row_ready_i = 1'($urandom);
                step();
            end
            cyc++;
        end
        row_ready_i = 1'b0;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: %0d rows left expected 0", exp_q.size());
            return;
        end
        rv = 1'b0;
        while (!rv && cyc < 800) begin
            checks++;
            if (valid_o !== 1'b0 || row_valid_o !== 1'b0 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL wait_res: valid_o=%b row_valid_o=%b ready_o=%b expected 0/0/0",
                         valid_o, row_valid_o, ready_o);
            end
            rv = rand_bp ? 1'($urandom) : 1'b1;
            res_valid_i = rv;
            res_i       = rv ? res : 4'($urandom);
            step();
            cyc++;
        end
        lat = cyc;
        res_valid_i = 1'b0;
        for (int k = 0; k <= out_stall; k++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== res || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL out: valid_o=%b data_o=%0d ready_o=%b expected 1/%0d/0",
                         valid_o, data_o, ready_o, res);
            end
            ready_i     = (k == out_stall);
            valid_i     = (out_stall > 0);
            res_valid_i = 1'($urandom);
            res_i       = ~res;
            step();
        end
        ready_i     = 1'b0;
        valid_i     = 1'b0;
        res_valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL out_done: valid_o=%b ready_o=%b expected 0/1", valid_o, ready_o);
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        #3;
        checks++;
        if (valid_o !== 1'b0 || row_valid_o !== 1'b0 || row_last_o !== 1'b0 ||
            data_o !== 4'd0 || row_idx_o !== 5'd0) begin
            errors++;
            $display("FAIL reset: valid=%b row_valid=%b last=%b data=%0d idx=%0d expected all 0",
                     valid_o, row_valid_o, row_last_o, data_o, row_idx_o);
        end
        step();
        reset_ni = 1'b1;
        step();
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_o=%b expected 1", ready_o);
        end
    endtask

    task automatic test_single_frame();
        int lat;
        int n;
        run_frame(rand_frame(0), -1, 0, 0, 1'b0, 4'd7, lat, n);
        checks++;
        if (lat !== ROWS + 2 || n !== ROWS) begin
            errors++;
            $display("FAIL latency: lat=%0d rows=%0d expected %0d/%0d", lat, n, ROWS + 2, ROWS);
        end
    endtask

    task automatic test_row_stall();
        int lat;
        int n;
        run_frame(rand_frame(0), 5, 3, 0, 1'b0, 4'd12, lat, n);
        checks++;
        if (lat !== ROWS + 5) begin
            errors++;
            $display("FAIL stall_latency: lat=%0d expected %0d", lat, ROWS + 5);
        end
    endtask

    task automatic test_out_backpressure();
        int lat;
        int n;
        run_frame(rand_frame(0), -1, 0, 10, 1'b0, 4'($urandom), lat, n);
        run_frame(rand_frame(0), -1, 0, 0, 1'b0, 4'd3, lat, n);
        checks++;
        if (lat !== ROWS + 2) begin
            errors++;
            $display("FAIL second_frame: lat=%0d expected %0d", lat, ROWS + 2);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        int lat;
        int n;
        valid_i = 1'b1;
        data_i  = rand_frame(0);
        step();
        valid_i     = 1'b0;
        row_ready_i = 1'b1;
        cyc = 0;
        while (row_idx_o !== 5'd12 && cyc < 100) begin
            step();
            cyc++;
        end
        checks++;
        if (row_idx_o !== 5'd12) begin
            errors++;
            $display("FAIL reach_row12: idx=%0d expected 12", row_idx_o);
        end
        #2 reset_ni = 1'b0;
        #1;
        checks++;
        if (row_valid_o !== 1'b0 || valid_o !== 1'b0 || row_idx_o !== 5'd0 ||
            row_last_o !== 1'b0 || data_o !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: row_valid=%b valid=%b idx=%0d last=%b data=%0d expected 0",
                     row_valid_o, valid_o, row_idx_o, row_last_o, data_o);
        end
        row_ready_i = 1'b0;
        step();
        reset_ni    = 1'b1;
        res_valid_i = 1'b1;
        res_i       = 4'd9;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stale_valid: valid_o=%b ready_o=%b expected 0/1", valid_o, ready_o);
            end
        end
        res_valid_i = 1'b0;
        run_frame(rand_frame(0), -1, 0, 0, 1'b0, 4'd5, lat, n);
    endtask

    task automatic test_sparse();
        frame_t f;
        int     lat;
        int     n;
        f = '0;
        f[3*COLS +: COLS]  = 28'h0000F01;
        f[20*COLS +: COLS] = 28'h8000000;
        run_frame(f, -1, 0, 0, 1'b0, 4'd14, lat, n);
        checks++;
`ifdef MODEL_SCHED_SKIP_ZERO_EN
        if (n !== 2) begin
`else
        if (n !== ROWS) begin
`endif
            errors++;
            $display("FAIL sparse_count: issued=%0d", n);
        end
        run_frame('0, -1, 0, 0, 1'b0, 4'd0, lat, n);
        checks++;
`ifdef MODEL_SCHED_SKIP_ZERO_EN
        if (n !== 1) begin
`else
        if (n !== ROWS) begin
`endif
            errors++;
            $display("FAIL zero_count: issued=%0d", n);
        end
    endtask

    task automatic test_random();
        int lat;
        int n;
        for (int i = 0; i < 8; i++) begin
            run_frame(rand_frame(40), -1, 0, int'($urandom_range(3)), 1'b1,
                      4'($urandom), lat, n);
        end
    endtask

    initial begin
        reset_ni    = 1'b1;
        valid_i     = 1'b0;
        data_i      = '0;
        row_ready_i = 1'b0;
        res_valid_i = 1'b0;
        res_i       = 4'd0;
        ready_i     = 1'b0;
        #2;
        test_reset();
        test_single_frame();
        test_row_stall();
        test_out_backpressure();
        test_mid_reset();
        test_sparse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/model_row_sched.md
MODEL_ROW_SCHED -- requirements
Module: model_row_sched

Interface
REQ-001 SHALL have parameter ROWS, default 28, meaning image rows per frame.
REQ-002 SHALL have parameter COLS, default 28, meaning pixels per row (1 bit each).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port valid_i, input, 1, image offer.
REQ-006 SHALL have port data_i, input, ROWS*COLS, image; row r occupies bits [r*COLS +: COLS].
REQ-007 SHALL have port ready_o, output, 1, image accept.
REQ-008 SHALL have port row_valid_o, output, 1, row issue to the compute engine.
REQ-009 SHALL have port row_data_o, output, COLS, current row bits.
REQ-010 SHALL have port row_idx_o, output, 5, current row index.
REQ-011 SHALL have port row_last_o, output, 1, final row of the frame.
REQ-012 SHALL have port row_ready_i, input, 1, engine accepts row.
REQ-013 SHALL have port res_valid_i, input, 1, engine class result valid.
REQ-014 SHALL have port res_i, input, 4, engine class (0-9).
REQ-015 SHALL have port valid_o, output, 1, classification valid.
REQ-016 SHALL have port data_o, output, 4, class.
REQ-017 SHALL have port ready_i, input, 1, downstream accept.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT_RES -> OUT -> IDLE.
REQ-019 IDLE: ready_o=1; on valid_i&&ready_o, capture data_i into the frame register, clear the row counter, and go to ISSUE next cycle.
REQ-020 ISSUE: row_valid_o=1, row_data_o/row_idx_o from the registered counter; these SHALL hold stable while row_ready_i=0.
REQ-021 ISSUE: on row_valid_o&&row_ready_i, the counter SHALL increment; after the row with row_last_o=1 is accepted, go to WAIT_RES.
REQ-022 row_last_o SHALL be 1 only when row_idx_o==ROWS-1 (or the last issued row, see REQ-031).
REQ-023 WAIT_RES: on res_valid_i, register res_i into data_o and go to OUT; res_valid_i SHALL be ignored in all other states.
REQ-024 OUT: valid_o=1, data_o stable; on ready_i, go to IDLE. ready_o SHALL be 0 in every state except IDLE (no frame overlap).
REQ-025 Minimum latency, accept to valid_o: ROWS+2 cycles with row_ready_i and res_valid_i held 1.
REQ-026 The row counter SHALL never exceed ROWS-1 and SHALL NOT wrap within a frame.
REQ-027 res_i values >9 SHALL be passed through unmodified (no saturation).

Reset
REQ-028 Assertion of reset_ni=0 SHALL immediately force IDLE, counter 0, valid_o=0, row_valid_o=0, row_last_o=0, data_o=0, and ready_o=1 after deassertion; a mid-frame reset SHALL discard the frame with no result emitted.
REQ-029 The frame register SHALL need no reset value.

Configuration
REQ-030 The macro MODEL_SCHED_SKIP_ZERO_EN SHALL enable skipping of all-zero rows.
REQ-031 When MODEL_SCHED_SKIP_ZERO_EN is defined, ISSUE SHALL advance past all-zero rows without asserting row_valid_o, at one row per cycle. The last non-zero row SHALL carry row_last_o. If every row is zero, row ROWS-1 SHALL be issued with row_last_o=1.
REQ-032 When MODEL_SCHED_SKIP_ZERO_EN is undefined, all ROWS rows SHALL be issued in order.

Structure
REQ-033 The shared package model_pkg SHALL hold the state enum, ROWS/COLS defaults, and the class width constant (4).
REQ-034 Sub-module model_row_mux (frame register row select, combinational) is natural; all other logic SHALL be inline.

Verification
REQ-035 Single frame, engine always ready, res_i=7 on the first WAIT_RES cycle: row_idx_o runs 0..27, then valid_o=1 with data_o=7 at cycle 30.
REQ-036 row_ready_i low for 3 cycles at row 5: row_idx_o=5 and row_data_o SHALL hold stable; total latency grows by 3.
REQ-037 ready_i low for 10 cycles in OUT, with valid_i held: ready_o=0 and valid_o/data_o stable throughout; the second frame is accepted only after the OUT handshake.
REQ-038 reset_ni pulsed low at row 12: outputs clear asynchronously; after release, the next frame starts at row_idx_o=0 and no stale valid_o appears.
REQ-039 With MODEL_SCHED_SKIP_ZERO_EN defined, an image with only rows 3 and 20 non-zero SHALL issue exactly 2 rows, with row_last_o on row 20. An all-zero image SHALL issue only row 27 with row_last_o=1.
